// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags.
// Reads return either a committed value or the ROB slot that will produce it.
// Commits are bypassed onto the read path in the same cycle.
module reg_rename_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              clear,
    input  logic              rename_flag,
    input  logic [REG_W-1:0]  rename_rd,
    input  logic [ROB_W-1:0]  rename_robpos,
    input  logic              unlock,
    input  logic [REG_W-1:0]  unlock_rd,
    input  logic [ROB_W-1:0]  unlock_robpos,
    input  logic [DATA_W-1:0] unlock_val,
    input  logic [REG_W-1:0]  rs1_addr,
    input  logic [REG_W-1:0]  rs2_addr,
    output logic              rs1_busy,
    output logic [ROB_W-1:0]  rs1_robpos,
    output logic [DATA_W-1:0] rs1_val,
    output logic              rs2_busy,
    output logic [ROB_W-1:0]  rs2_robpos,
    output logic [DATA_W-1:0] rs2_val,
    output logic [5:0]        busy_cnt
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned LK_W  = 1 + ROB_W + DATA_W;

    logic [DATA_W-1:0]  val_q [REG_NUM];
    logic [DATA_W-1:0]  val_d [REG_NUM];
    logic [ROB_W-1:0]   tag_q [REG_NUM];
    logic [ROB_W-1:0]   tag_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [CNT_W-1:0]   busy_cnt_q;
    logic [CNT_W-1:0]   busy_cnt_d;

    logic commit_c;
    logic rename_c;

    // x0 writes are discarded; rename is stalled by ready and suppressed by flush
    assign commit_c = unlock && (unlock_rd != '0);
    assign rename_c = ready && rename_flag && (rename_rd != '0) && !clear;

    // Operand lookup: x0 is zero, a matching commit is bypassed, else state
    function automatic logic [LK_W-1:0] lookup(input logic [REG_W-1:0] addr);
        logic              b;
        logic [ROB_W-1:0]  p;
        logic [DATA_W-1:0] v;
        b = 1'b0;
        p = '0;
        v = '0;
        if (addr != '0) begin
            p = tag_q[addr];
            if (busy_q[addr] && unlock && (unlock_rd == addr) &&
                (unlock_robpos == tag_q[addr])) begin
                v = unlock_val;
            end else begin
                b = busy_q[addr];
                v = val_q[addr];
            end
        end
        return {b, p, v};
    endfunction

    // Combinational read ports; same-cycle renames are not visible here
    always_comb begin
        {rs1_busy, rs1_robpos, rs1_val} = lookup(rs1_addr);
        {rs2_busy, rs2_robpos, rs2_val} = lookup(rs2_addr);
    end

    // Next-state: commit writes value, rename overrides busy/tag, flush clears busy
    always_comb begin
        val_d      = val_q;
        tag_d      = tag_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        if (commit_c) begin
            val_d[unlock_rd] = unlock_val;
            if (tag_q[unlock_rd] == unlock_robpos) begin
                busy_d[unlock_rd] = 1'b0;
            end
        end
        if (clear) begin
            busy_d = '0;
        end else if (rename_c) begin
            busy_d[rename_rd] = 1'b1;
            tag_d[rename_rd]  = rename_robpos;
        end
        busy_d[0] = 1'b0;
        val_d[0]  = '0;
        tag_d[0]  = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed vector table plus reset corner sequences.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready, clear, rename_flag, unlock;
    logic [4:0]  rename_rd, unlock_rd, rs1_addr, rs2_addr;
    logic [3:0]  rename_robpos, unlock_robpos;
    logic [31:0] unlock_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_robpos, rs2_robpos;
    logic [31:0] rs1_val, rs2_val;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    reg_rename_file dut (
        .clk(clk), .reset(reset), .ready(ready), .clear(clear),
        .rename_flag(rename_flag), .rename_rd(rename_rd), .rename_robpos(rename_robpos),
        .unlock(unlock), .unlock_rd(unlock_rd), .unlock_robpos(unlock_robpos),
        .unlock_val(unlock_val), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs1_robpos(rs1_robpos), .rs1_val(rs1_val),
        .rs2_busy(rs2_busy), .rs2_robpos(rs2_robpos), .rs2_val(rs2_val),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, clr, ren;
        logic [4:0]  rrd;
        logic [3:0]  rpos;
        logic        unl;
        logic [4:0]  urd;
        logic [3:0]  upos;
        logic [31:0] uval;
        logic [4:0]  a1, a2;
        logic        b1;
        logic [3:0]  p1;
        logic [31:0] v1;
        logic        b2;
        logic [3:0]  p2;
        logic [31:0] v2;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rdy, clr, ren, input logic [4:0] rrd, input logic [3:0] rpos,
        input logic unl, input logic [4:0] urd, input logic [3:0] upos, input logic [31:0] uval,
        input logic [4:0] a1, a2,
        input logic b1, input logic [3:0] p1, input logic [31:0] v1,
        input logic b2, input logic [3:0] p2, input logic [31:0] v2,
        input logic [5:0] cnt);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.ren = ren; v.rrd = rrd; v.rpos = rpos;
        v.unl = unl; v.urd = urd; v.upos = upos; v.uval = uval;
        v.a1 = a1; v.a2 = a2;
        v.b1 = b1; v.p1 = p1; v.v1 = v1;
        v.b2 = b2; v.p2 = p2; v.v2 = v2;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Busy flag always checked; robpos only when busy, value only when not busy
    task automatic chk_port(input string tag, input logic b, input logic [3:0] p,
                            input logic [31:0] v, input logic eb, input logic [3:0] ep,
                            input logic [31:0] ev);
        chk({tag, "_busy"}, 32'(b), 32'(eb));
        if (eb) chk({tag, "_robpos"}, 32'(p), 32'(ep));
        else    chk({tag, "_val"}, v, ev);
    endtask

    task automatic idle();
        ready = 1'b1; clear = 1'b0; rename_flag = 1'b0; rename_rd = '0; rename_robpos = '0;
        unlock = 1'b0; unlock_rd = '0; unlock_robpos = '0; unlock_val = '0;
    endtask

    initial begin
        // rdy clr ren rrd rpos | unl urd upos uval | a1 a2 | b1 p1 v1 | b2 p2 v2 | cnt
        vecs[0]  = mk(1,0,0,0,0, 0,0,0,0,            5,0, 0,0,0,            0,0,0,        0);
        vecs[1]  = mk(1,0,1,5,3, 0,0,0,0,            5,0, 0,0,0,            0,0,0,        1);
        vecs[2]  = mk(1,0,0,0,0, 0,0,0,0,            5,6, 1,3,0,            0,0,0,        1);
        vecs[3]  = mk(1,0,0,0,0, 1,5,3,32'hDEAD,     5,0, 0,0,32'hDEAD,     0,0,0,        0);
        vecs[4]  = mk(1,0,0,0,0, 0,0,0,0,            5,0, 0,0,32'hDEAD,     0,0,0,        0);
        vecs[5]  = mk(1,0,1,5,3, 0,0,0,0,            5,0, 0,0,32'hDEAD,     0,0,0,        1);
        vecs[6]  = mk(1,0,1,5,7, 0,0,0,0,            5,0, 1,3,0,            0,0,0,        1);
        vecs[7]  = mk(1,0,0,0,0, 1,5,3,32'h11,       5,0, 1,7,0,            0,0,0,        1);
        vecs[8]  = mk(1,0,0,0,0, 0,0,0,0,            5,6, 1,7,0,            0,0,0,        1);
        vecs[9]  = mk(1,0,1,6,4, 0,0,0,0,            6,5, 0,0,0,            1,7,0,        2);
        vecs[10] = mk(1,0,1,6,4, 1,6,4,32'h22,       6,5, 0,0,32'h22,       1,7,0,        2);
        vecs[11] = mk(1,0,0,0,0, 0,0,0,0,            6,5, 1,4,0,            1,7,0,        2);
        vecs[12] = mk(1,0,0,0,0, 1,5,7,32'h77,       5,6, 0,0,32'h77,       1,4,0,        1);
        vecs[13] = mk(1,0,0,0,0, 1,6,4,32'h66,       6,5, 0,0,32'h66,       0,0,32'h77,   0);
        vecs[14] = mk(1,0,1,1,1, 0,0,0,0,            1,0, 0,0,0,            0,0,0,        1);
        vecs[15] = mk(1,0,1,2,2, 0,0,0,0,            2,1, 0,0,0,            1,1,0,        2);
        vecs[16] = mk(1,0,1,3,3, 0,0,0,0,            1,2, 1,1,0,            1,2,0,        3);
        vecs[17] = mk(1,1,1,4,5, 1,1,1,32'h40,       1,3, 0,0,32'h40,       1,3,0,        0);
        vecs[18] = mk(1,0,0,0,0, 0,0,0,0,            1,4, 0,0,32'h40,       0,0,0,        0);
        vecs[19] = mk(0,0,1,9,2, 0,0,0,0,            9,2, 0,0,0,            0,0,0,        0);
        vecs[20] = mk(1,0,0,0,0, 0,0,0,0,            9,3, 0,0,0,            0,0,0,        0);
        vecs[21] = mk(1,0,1,0,5, 0,0,0,0,            0,9, 0,0,0,            0,0,0,        0);
        vecs[22] = mk(1,0,0,0,0, 1,0,5,32'hBEEF,     0,0, 0,0,0,            0,0,0,        0);
        vecs[23] = mk(1,0,0,0,0, 0,0,0,0,            0,6, 0,0,0,            0,0,32'h66,   0);
        vecs[24] = mk(1,0,1,7,2, 0,0,0,0,            7,0, 0,0,0,            0,0,0,        1);
        vecs[25] = mk(0,0,0,0,0, 1,7,2,32'h55,       7,0, 0,0,32'h55,       0,0,0,        0);
        vecs[26] = mk(1,0,0,0,0, 0,0,0,0,            7,0, 0,0,32'h55,       0,0,0,        0);

        // Reset held: every output reads zero
        reset = 1'b1;
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        #12;
        chk("rst_rs1_busy", 32'(rs1_busy), 0);
        chk("rst_rs1_robpos", 32'(rs1_robpos), 0);
        chk("rst_rs1_val", rs1_val, 0);
        chk("rst_rs2_busy", 32'(rs2_busy), 0);
        chk("rst_rs2_val", rs2_val, 0);
        chk("rst_cnt", 32'(busy_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: drive on negedge, check reads before the edge, count after it
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ready = vecs[i].rdy; clear = vecs[i].clr;
            rename_flag = vecs[i].ren; rename_rd = vecs[i].rrd; rename_robpos = vecs[i].rpos;
            unlock = vecs[i].unl; unlock_rd = vecs[i].urd;
            unlock_robpos = vecs[i].upos; unlock_val = vecs[i].uval;
            rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            #1;
            chk_port($sformatf("v%0d_rs1", i), rs1_busy, rs1_robpos, rs1_val,
                     vecs[i].b1, vecs[i].p1, vecs[i].v1);
            chk_port($sformatf("v%0d_rs2", i), rs2_busy, rs2_robpos, rs2_val,
                     vecs[i].b2, vecs[i].p2, vecs[i].v2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(vecs[i].cnt));
        end

        // Async reset between edges clears state immediately
        @(negedge clk);
        idle();
        rename_flag = 1'b1; rename_rd = 5'd8; rename_robpos = 4'd6;
        rs1_addr = 5'd8; rs2_addr = 5'd7;
        @(posedge clk);
        #1;
        idle();
        chk("pre_rst_cnt", 32'(busy_cnt), 1);
        chk("pre_rst_busy8", 32'(rs1_busy), 1);
        chk("pre_rst_pos8", 32'(rs1_robpos), 6);
        chk("pre_rst_val7", rs2_val, 32'h55);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy8", 32'(rs1_busy), 0);
        chk("mid_rst_pos8", 32'(rs1_robpos), 0);
        chk("mid_rst_val7", rs2_val, 0);
        chk("mid_rst_cnt", 32'(busy_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // First edge after release behaves normally
        rename_flag = 1'b1; rename_rd = 5'd10; rename_robpos = 4'd1;
        rs1_addr = 5'd10;
        @(posedge clk);
        #1;
        idle();
        chk("post_rst_cnt", 32'(busy_cnt), 1);
        chk("post_rst_busy10", 32'(rs1_busy), 1);
        chk("post_rst_pos10", 32'(rs1_robpos), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
